ece241_q2_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises the 4-input SOP/POS function unit (inputs a,b,c,d; outputs out_sop, out_pos) across all 16 input codes.
- Captures both outputs into 16-bit truth-table registers and cross-checks SOP against POS.
- Reports mismatch status through a start/busy/done handshake.
- Sits between a test/config master and one instance of the function unit, whose outputs may be registered with a fixed latency.

---
 rtl/ece241_q2_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_ece241_q2_sweep_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ece241_q2_sweep_ctrl.sv
// Sweep sequencer for the 4-input SOP/POS function unit: walks all 16 codes,
// captures both outputs into truth tables and records SOP/POS disagreements.
module ece241_q2_sweep_ctrl #(
    parameter int EVAL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        sop_in,
    input  logic        pos_in,
    output logic [15:0] tt_sop,
    output logic [15:0] tt_pos,
    output logic        mismatch,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_bad
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [2:0] LAT = 3'(EVAL_LAT);

    state_t      r_state;
    logic [3:0]  r_code;
    logic [2:0]  r_wcnt;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_abcd;
    logic [15:0] r_tt_sop;
    logic [15:0] r_tt_pos;
    logic        r_mismatch;
    logic [4:0]  r_mm_cnt;
    logic [3:0]  r_first_bad;

    logic w_sample;
    logic w_diff;

    assign w_sample = (r_wcnt == LAT);
    assign w_diff   = sop_in ^ pos_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_code      <= 4'd0;
            r_wcnt      <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_abcd      <= 4'd0;
            r_tt_sop    <= 16'd0;
            r_tt_pos    <= 16'd0;
            r_mismatch  <= 1'b0;
            r_mm_cnt    <= 5'd0;
            r_first_bad <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_abcd <= 4'd0;
                    if (start) begin
                        r_state     <= S_RUN;
                        r_code      <= 4'd0;
                        r_wcnt      <= 3'd0;
                        r_busy      <= 1'b1;
                        r_tt_sop    <= 16'd0;
                        r_tt_pos    <= 16'd0;
                        r_mismatch  <= 1'b0;
                        r_mm_cnt    <= 5'd0;
                        r_first_bad <= 4'd0;
                    end
                end
                S_RUN: begin
                    // abort wins over a sample on the same edge
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_abcd  <= 4'd0;
                        r_code  <= 4'd0;
                        r_wcnt  <= 3'd0;
                    end else if (w_sample) begin
                        r_tt_sop[r_code] <= sop_in;
                        r_tt_pos[r_code] <= pos_in;
                        if (w_diff) begin
                            r_mm_cnt   <= r_mm_cnt + 5'd1;
                            r_mismatch <= 1'b1;
                            if (!r_mismatch) r_first_bad <= r_code;
                        end
                        if (r_code == 4'd15) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_abcd  <= 4'd0;
                            r_wcnt  <= 3'd0;
                        end else begin
                            r_code <= r_code + 4'd1;
                            r_abcd <= r_code + 4'd1;
                            r_wcnt <= 3'd0;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_code  <= 4'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_abcd  <= 4'd0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign {a, b, c, d} = r_abcd;
    assign tt_sop       = r_tt_sop;
    assign tt_pos       = r_tt_pos;
    assign mismatch     = r_mismatch;
    assign mismatch_cnt = r_mm_cnt;
    assign first_bad    = r_first_bad;

endmodule

// File: tb/tb_ece241_q2_sweep_ctrl.sv
// Bench for ece241_q2_sweep_ctrl: two instances (EVAL_LAT=1 and 0) driven by a
// table-based function unit; results compared against a truth-table model.
module tb_ece241_q2_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_d, abort_d, use0;
    logic [15:0] sop_tab, pos_tab;

    logic        start1, abort1, busy1, done1, a1, b1, c1, d1, sop1, pos1, mm1;
    logic [15:0] tts1, ttp1;
    logic [4:0]  cnt1;
    logic [3:0]  fb1;
    logic        start0, abort0, busy0, done0, a0, b0, c0, d0, sop0, pos0, mm0;
    logic [15:0] tts0, ttp0;
    logic [4:0]  cnt0;
    logic [3:0]  fb0;

    assign start1 = start_d & ~use0;
    assign abort1 = abort_d & ~use0;
    assign start0 = start_d & use0;
    assign abort0 = abort_d & use0;
    assign sop1   = sop_tab[{a1, b1, c1, d1}];
    assign pos1   = pos_tab[{a1, b1, c1, d1}];
    assign sop0   = sop_tab[{a0, b0, c0, d0}];
    assign pos0   = pos_tab[{a0, b0, c0, d0}];

    ece241_q2_sweep_ctrl #(.EVAL_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .a(a1), .b(b1), .c(c1), .d(d1),
        .sop_in(sop1), .pos_in(pos1), .tt_sop(tts1), .tt_pos(ttp1),
        .mismatch(mm1), .mismatch_cnt(cnt1), .first_bad(fb1)
    );

    ece241_q2_sweep_ctrl #(.EVAL_LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .a(a0), .b(b0), .c(c0), .d(d0),
        .sop_in(sop0), .pos_in(pos0), .tt_sop(tts0), .tt_pos(ttp0),
        .mismatch(mm0), .mismatch_cnt(cnt0), .first_bad(fb0)
    );

    logic        m_busy, m_done, m_mm;
    logic [3:0]  m_code, m_fb;
    logic [15:0] m_tts, m_ttp;
    logic [4:0]  m_cnt;

    assign m_busy = use0 ? busy0 : busy1;
    assign m_done = use0 ? done0 : done1;
    assign m_code = use0 ? {a0, b0, c0, d0} : {a1, b1, c1, d1};
    assign m_tts  = use0 ? tts0 : tts1;
    assign m_ttp  = use0 ? ttp0 : ttp1;
    assign m_mm   = use0 ? mm0 : mm1;
    assign m_cnt  = use0 ? cnt0 : cnt1;
    assign m_fb   = use0 ? fb0 : fb1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 16'(m_busy), 16'd0);
        chk({tag, "_done"}, 16'(m_done), 16'd0);
        chk({tag, "_code"}, 16'(m_code), 16'd0);
        chk({tag, "_tts"}, m_tts, 16'd0);
        chk({tag, "_ttp"}, m_ttp, 16'd0);
        chk({tag, "_mm"}, 16'(m_mm), 16'd0);
        chk({tag, "_cnt"}, 16'(m_cnt), 16'd0);
        chk({tag, "_fb"}, 16'(m_fb), 16'd0);
    endtask

    // Expected results after the first ncodes codes have been sampled.
    task automatic check_results(input int ncodes);
        logic [15:0] es, ep;
        int cnt, fb;
        bit any;
        es = 16'd0; ep = 16'd0; cnt = 0; fb = 0; any = 1'b0;
        for (int k = 0; k < ncodes; k++) begin
            es[k] = sop_tab[k];
            ep[k] = pos_tab[k];
            if (sop_tab[k] != pos_tab[k]) begin
                if (!any) fb = k;
                any = 1'b1;
                cnt++;
            end
        end
        chk("tt_sop", m_tts, es);
        chk("tt_pos", m_ttp, ep);
        chk("mismatch", 16'(m_mm), 16'(any));
        chk("mismatch_cnt", 16'(m_cnt), 16'(cnt));
        chk("first_bad", 16'(m_fb), 16'(fb));
    endtask

    // One sweep on the selected instance. ab_k >= 0 aborts on the edge that would
    // sample code ab_k. poke drives start during RUN and during FIN.
    task automatic do_sweep(input int L, input int ab_k, input bit poke);
        int last, fin;
        fin  = 16 * (L + 1) + 1;
        last = (ab_k >= 0) ? (ab_k + 1) * (L + 1) : 16 * (L + 1);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        chk("clr_tts", m_tts, 16'd0);
        chk("clr_cnt", 16'(m_cnt), 16'd0);
        for (int n = 1; n <= last + 5; n++) begin
            abort_d = (ab_k >= 0) && (n == last);
            start_d = poke && (ab_k < 0) && (n == 3 || n == fin);
            chk("busy", 16'(m_busy), 16'(n <= last));
            chk("done", 16'(m_done), 16'((ab_k < 0) && (n == fin)));
            chk("code", 16'(m_code), (n <= last) ? 16'((n - 1) / (L + 1)) : 16'd0);
            tick();
        end
        abort_d = 1'b0;
        start_d = 1'b0;
        check_results((ab_k >= 0) ? ab_k : 16);
    endtask

    initial begin
        int L, ab;
        reset = 1'b1; start_d = 1'b0; abort_d = 1'b0; use0 = 1'b0;
        sop_tab = 16'd0; pos_tab = 16'd0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            use0 = 1'b0; #0 check_zero("rst1");
            use0 = 1'b1; #0 check_zero("rst0");
            tick();
        end

        // Golden model, EVAL_LAT=1
        use0 = 1'b0;
        sop_tab = 16'h8084; pos_tab = 16'h8084;
        do_sweep(1, -1, 1'b0);
        chk("golden_tts", m_tts, 16'h8084);

        // POS forced high at codes 4 and 9
        pos_tab = 16'h8294;
        do_sweep(1, -1, 1'b1);
        chk("forced_ttp", m_ttp, 16'h8294);
        chk("forced_fb", 16'(m_fb), 16'd4);

        // EVAL_LAT=0, one code per cycle
        use0 = 1'b1;
        sop_tab = 16'h5555; pos_tab = 16'h5555;
        do_sweep(0, -1, 1'b1);
        chk("lat0_tts", m_tts, 16'h5555);

        // Every code mismatches: count reaches 16
        sop_tab = 16'hFFFF; pos_tab = 16'h0000;
        do_sweep(0, -1, 1'b0);
        chk("all_bad_cnt", 16'(m_cnt), 16'd16);

        // Abort at code 2, then a clean restart
        use0 = 1'b0;
        sop_tab = 16'h0007; pos_tab = 16'h0004;
        do_sweep(1, 2, 1'b0);
        chk("abort_bit2", 16'(m_tts[2]), 16'd0);
        sop_tab = 16'hA5A5; pos_tab = 16'hA5A5;
        do_sweep(1, -1, 1'b0);

        // Reset in the middle of a sweep
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_busy", 16'(m_busy), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("midrst");
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_busy", 16'(m_busy), 16'd0);
            chk("post_rst_done", 16'(m_done), 16'd0);
            tick();
        end

        // Randomized sweeps
        for (int i = 0; i < 8; i++) begin
            sop_tab = 16'($urandom);
            pos_tab = sop_tab ^ 16'($urandom & $urandom);
            use0 = 1'($urandom_range(0, 1));
            L = use0 ? 0 : 1;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            do_sweep(L, ab, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
